yazmac_obegi: RTL and testbench
===============================

Name: yazmac_obegi

Overview:
Integer register file and per-register scoreboard; receiving end of the writeback stage's yo_* write interface. Holds architectural x0..x31, marks registers busy when issue allocates a destination, and clears busy when writeback returns the matching tag. Serves two read ports to decode/issue with value, busy flag and pending producer tag.

Parameters:
VERI_BIT, 32, data width per register
YAZMAC_BIT, 5, register address width (2^YAZMAC_BIT registers)
UOP_TAG_BIT, 4, uop tag width

Ports:
clk_i  input  1  clock
rstn_i  input  1  reset, asynchronous, active-low
yo_veri_i  input  VERI_BIT  writeback data
yo_adres_i  input  YAZMAC_BIT  writeback destination
yo_etiket_i  input  UOP_TAG_BIT  writeback uop tag
yo_gecerli_i  input  1  writeback valid
ayir_gecerli_i  input  1  issue allocates a destination this cycle
ayir_adres_i  input  YAZMAC_BIT  allocated destination
ayir_etiket_i  input  UOP_TAG_BIT  tag of allocating uop
temizle_i  input  1  pipeline flush; drop all reservations
oku1_adres_i  input  YAZMAC_BIT  read port 1 address
oku1_veri_o  output  VERI_BIT  read port 1 data
oku1_mesgul_o  output  1  read port 1 register pending
oku1_etiket_o  output  UOP_TAG_BIT  read port 1 pending producer tag
oku2_adres_i  input  YAZMAC_BIT  read port 2 address
oku2_veri_o  output  VERI_BIT  read port 2 data
oku2_mesgul_o  output  1  read port 2 register pending
oku2_etiket_o  output  UOP_TAG_BIT  read port 2 pending producer tag

Behaviour:
- State per register i: veri_r[i], mesgul_r[i], etiket_r[i]. Async reset (rstn_i low): all cleared to 0 immediately; outputs therefore read 0/0/0. Reset mid-operation discards all reservations and data.
- x0: reads always return veri 0, mesgul 0, etiket 0; writes and allocations to x0 ignored.
- Writeback (posedge, yo_gecerli_i=1, yo_adres_i!=0): veri_r[adr] <= yo_veri_i unconditionally (writeback is in program order). mesgul_r[adr] <= 0 only if mesgul_r[adr]=1 and etiket_r[adr]==yo_etiket_i; tag mismatch leaves busy/tag untouched (a younger writer owns it).
- Allocation (posedge, ayir_gecerli_i=1, ayir_adres_i!=0, temizle_i=0): mesgul_r[adr] <= 1, etiket_r[adr] <= ayir_etiket_i.
- Same register, same cycle, writeback and allocation: data written, allocation wins busy/tag (result busy=1, tag=ayir_etiket_i).
- Flush (temizle_i=1): all mesgul_r <= 0; allocation that cycle ignored; writeback data that cycle still written.
- Reads combinational from state (zero-cycle latency); mesgul_o=mesgul_r, etiket_o=etiket_r. With bypass (see option) the same-cycle writeback is visible.
- Both read ports independent; same address on both gives identical outputs.
- No handshake/backpressure: writeback and allocation always accepted.

Optional Feature:
YO_BYPASS_EN. Defined: if yo_gecerli_i, yo_adres_i==oku_adres_i!=0, read data = yo_veri_i, and if that register is busy with matching tag, mesgul_o=0 and etiket_o=0 in the same cycle. Undefined: reads see registered state only; writeback becomes visible the cycle after.

Decomposition:
- VERI_BIT, YAZMAC_BIT, UOP_TAG_BIT, LOW/HIGH from shared sabitler.vh; no new package entries beyond a YAZMAC_SAYISI constant (2^YAZMAC_BIT).
- One sub-module, yazmac_okuma_portu: read mux plus x0 masking plus optional bypass; instantiated twice.

Test Plan:
- Reset low mid-run after writing x5=0x1234 -> all read outputs 0 asynchronously; after release oku1(x5) = 0x00000000, mesgul 0.
- Allocate x3 tag 2; next cycle oku1(x3) mesgul=1 etiket=2; writeback x3 tag 2 data 0xDEADBEEF -> next cycle veri=0xDEADBEEF, mesgul=0.
- Allocate x7 tag 1, then x7 tag 4; writeback x7 tag 1 data 0xAA -> veri=0xAA, mesgul stays 1, etiket 4; writeback tag 4 data 0xBB -> mesgul 0, veri 0xBB.
- Same cycle writeback x9 tag 3 (busy tag 3) and allocate x9 tag 6 -> veri updated, mesgul=1, etiket=6.
- Allocate x4, x8 then temizle_i=1 with simultaneous allocate x10 -> x4,x8,x10 all mesgul 0.
- Writeback/allocate x0 with 0xFFFFFFFF -> both ports read x0 = 0, mesgul 0; with YO_BYPASS_EN, writeback x12 0x55 while reading x12 -> 0x55 same cycle, without it next cycle.

Source files
------------

// File: rtl/yazmac_obegi_pkg.sv
// Shared constants for the integer register file and its scoreboard.
package yazmac_obegi_pkg;
  localparam int unsigned VERI_BIT      = 32;
  localparam int unsigned YAZMAC_BIT    = 5;
  localparam int unsigned UOP_TAG_BIT   = 4;
  localparam int unsigned YAZMAC_SAYISI = 1 << YAZMAC_BIT;
  localparam logic        LOW           = 1'b0;
  localparam logic        HIGH          = 1'b1;
endpackage

// File: rtl/yazmac_okuma_portu.sv
// One register-file read port: state mux, x0 masking, optional writeback
// bypass when YO_BYPASS_EN is defined.
module yazmac_okuma_portu
  import yazmac_obegi_pkg::*;
(
  input  logic [YAZMAC_BIT-1:0]                       adres,
  input  logic [YAZMAC_SAYISI-1:0][VERI_BIT-1:0]      veri_r,
  input  logic [YAZMAC_SAYISI-1:0]                    mesgul_r,
  input  logic [YAZMAC_SAYISI-1:0][UOP_TAG_BIT-1:0]   etiket_r,
  input  logic [VERI_BIT-1:0]                         yo_veri,
  input  logic [YAZMAC_BIT-1:0]                       yo_adres,
  input  logic [UOP_TAG_BIT-1:0]                      yo_etiket,
  input  logic                                        yo_gecerli,
  output logic [VERI_BIT-1:0]                         veri,
  output logic                                        mesgul,
  output logic [UOP_TAG_BIT-1:0]                      etiket
);

`ifndef YO_BYPASS_EN
  logic unused_yo;
  assign unused_yo = ^{yo_veri, yo_adres, yo_etiket, yo_gecerli};
`endif

  always_comb begin
    veri   = veri_r[adres];
    mesgul = mesgul_r[adres];
    etiket = etiket_r[adres];
`ifdef YO_BYPASS_EN
    // A matching writeback retires the pending producer in the same cycle.
    if (yo_gecerli && (yo_adres == adres)) begin
      veri = yo_veri;
      if (mesgul_r[adres] && (etiket_r[adres] == yo_etiket)) begin
        mesgul = LOW;
        etiket = '0;
      end
    end
`endif
    if (adres == '0) begin
      veri   = '0;
      mesgul = LOW;
      etiket = '0;
    end
  end

endmodule

// File: rtl/yazmac_obegi.sv
// Integer register file x0..x31 with per-register busy/tag scoreboard.
// Build option: YO_BYPASS_EN forwards same-cycle writeback to both read ports.
module yazmac_obegi
  import yazmac_obegi_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [VERI_BIT-1:0]     yo_veri_i,
  input  logic [YAZMAC_BIT-1:0]   yo_adres_i,
  input  logic [UOP_TAG_BIT-1:0]  yo_etiket_i,
  input  logic                    yo_gecerli_i,
  input  logic                    ayir_gecerli_i,
  input  logic [YAZMAC_BIT-1:0]   ayir_adres_i,
  input  logic [UOP_TAG_BIT-1:0]  ayir_etiket_i,
  input  logic                    temizle_i,
  input  logic [YAZMAC_BIT-1:0]   oku1_adres_i,
  output logic [VERI_BIT-1:0]     oku1_veri_o,
  output logic                    oku1_mesgul_o,
  output logic [UOP_TAG_BIT-1:0]  oku1_etiket_o,
  input  logic [YAZMAC_BIT-1:0]   oku2_adres_i,
  output logic [VERI_BIT-1:0]     oku2_veri_o,
  output logic                    oku2_mesgul_o,
  output logic [UOP_TAG_BIT-1:0]  oku2_etiket_o
);

  logic [YAZMAC_SAYISI-1:0][VERI_BIT-1:0]    veri_r;
  logic [YAZMAC_SAYISI-1:0]                  mesgul_r;
  logic [YAZMAC_SAYISI-1:0][UOP_TAG_BIT-1:0] etiket_r;

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      veri_r   <= '0;
      mesgul_r <= '0;
      etiket_r <= '0;
    end else begin
      for (int unsigned i = 1; i < YAZMAC_SAYISI; i++) begin
        if (yo_gecerli_i && (yo_adres_i == YAZMAC_BIT'(i))) begin
          veri_r[i] <= yo_veri_i;
          if (mesgul_r[i] && (etiket_r[i] == yo_etiket_i))
            mesgul_r[i] <= LOW;
        end
        // Later assignments win: flush beats allocation, allocation beats release.
        if (temizle_i) begin
          mesgul_r[i] <= LOW;
        end else if (ayir_gecerli_i && (ayir_adres_i == YAZMAC_BIT'(i))) begin
          mesgul_r[i] <= HIGH;
          etiket_r[i] <= ayir_etiket_i;
        end
      end
    end
  end

  yazmac_okuma_portu u_oku1 (
    .adres      (oku1_adres_i),
    .veri_r     (veri_r),
    .mesgul_r   (mesgul_r),
    .etiket_r   (etiket_r),
    .yo_veri    (yo_veri_i),
    .yo_adres   (yo_adres_i),
    .yo_etiket  (yo_etiket_i),
    .yo_gecerli (yo_gecerli_i),
    .veri       (oku1_veri_o),
    .mesgul     (oku1_mesgul_o),
    .etiket     (oku1_etiket_o)
  );

  yazmac_okuma_portu u_oku2 (
    .adres      (oku2_adres_i),
    .veri_r     (veri_r),
    .mesgul_r   (mesgul_r),
    .etiket_r   (etiket_r),
    .yo_veri    (yo_veri_i),
    .yo_adres   (yo_adres_i),
    .yo_etiket  (yo_etiket_i),
    .yo_gecerli (yo_gecerli_i),
    .veri       (oku2_veri_o),
    .mesgul     (oku2_mesgul_o),
    .etiket     (oku2_etiket_o)
  );

endmodule

// File: tb/tb_yazmac_obegi.sv
// Scoreboard bench for yazmac_obegi: stimulus queues expected read results,
// a monitor compares them at the falling edge (or on demand for async reset).
module tb_yazmac_obegi;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic [31:0] yo_veri_i;
  logic [4:0]  yo_adres_i;
  logic [3:0]  yo_etiket_i;
  logic        yo_gecerli_i;
  logic        ayir_gecerli_i;
  logic [4:0]  ayir_adres_i;
  logic [3:0]  ayir_etiket_i;
  logic        temizle_i;
  logic [4:0]  oku1_adres_i, oku2_adres_i;
  logic [31:0] oku1_veri_o, oku2_veri_o;
  logic        oku1_mesgul_o, oku2_mesgul_o;
  logic [3:0]  oku1_etiket_o, oku2_etiket_o;

  always #5 clk = ~clk;

  yazmac_obegi dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .yo_veri_i      (yo_veri_i),
    .yo_adres_i     (yo_adres_i),
    .yo_etiket_i    (yo_etiket_i),
    .yo_gecerli_i   (yo_gecerli_i),
    .ayir_gecerli_i (ayir_gecerli_i),
    .ayir_adres_i   (ayir_adres_i),
    .ayir_etiket_i  (ayir_etiket_i),
    .temizle_i      (temizle_i),
    .oku1_adres_i   (oku1_adres_i),
    .oku1_veri_o    (oku1_veri_o),
    .oku1_mesgul_o  (oku1_mesgul_o),
    .oku1_etiket_o  (oku1_etiket_o),
    .oku2_adres_i   (oku2_adres_i),
    .oku2_veri_o    (oku2_veri_o),
    .oku2_mesgul_o  (oku2_mesgul_o),
    .oku2_etiket_o  (oku2_etiket_o)
  );

  typedef struct packed {
    logic [31:0] v1; logic m1; logic [3:0] t1;
    logic [31:0] v2; logic m2; logic [3:0] t2;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  event  probe_ev;
  int    checks = 0;
  int    failures = 0;

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk or probe_ev);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if ({oku1_veri_o, oku1_mesgul_o, oku1_etiket_o} !== {e.v1, e.m1, e.t1}) begin
          failures++;
          $display("FAIL %s port1: got veri=%h mesgul=%b etiket=%h, want veri=%h mesgul=%b etiket=%h",
                   nm, oku1_veri_o, oku1_mesgul_o, oku1_etiket_o, e.v1, e.m1, e.t1);
        end
        checks++;
        if ({oku2_veri_o, oku2_mesgul_o, oku2_etiket_o} !== {e.v2, e.m2, e.t2}) begin
          failures++;
          $display("FAIL %s port2: got veri=%h mesgul=%b etiket=%h, want veri=%h mesgul=%b etiket=%h",
                   nm, oku2_veri_o, oku2_mesgul_o, oku2_etiket_o, e.v2, e.m2, e.t2);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation checked at the next falling edge.
  task automatic chk(input string nm,
                     input logic [4:0] a1, input logic [31:0] v1, input logic m1, input logic [3:0] t1,
                     input logic [4:0] a2, input logic [31:0] v2, input logic m2, input logic [3:0] t2);
    oku1_adres_i = a1;
    oku2_adres_i = a2;
    exp_q.push_back(exp_t'{v1, m1, t1, v2, m2, t2});
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  // Queue an expectation checked immediately, with no clock edge involved.
  task automatic chk_now(input string nm,
                         input logic [4:0] a1, input logic [31:0] v1, input logic m1, input logic [3:0] t1,
                         input logic [4:0] a2, input logic [31:0] v2, input logic m2, input logic [3:0] t2);
    oku1_adres_i = a1;
    oku2_adres_i = a2;
    #1;
    exp_q.push_back(exp_t'{v1, m1, t1, v2, m2, t2});
    name_q.push_back(nm);
    -> probe_ev;
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic [3:0] t);
    yo_gecerli_i = 1'b1; yo_adres_i = a; yo_veri_i = d; yo_etiket_i = t;
  endtask

  task automatic ayir(input logic [4:0] a, input logic [3:0] t);
    ayir_gecerli_i = 1'b1; ayir_adres_i = a; ayir_etiket_i = t;
  endtask

  task automatic idle();
    yo_gecerli_i = 1'b0; ayir_gecerli_i = 1'b0; temizle_i = 1'b0;
  endtask

  initial begin : stimulus
    rstn_i = 1'b0;
    yo_veri_i = '0; yo_adres_i = '0; yo_etiket_i = '0; yo_gecerli_i = 1'b0;
    ayir_gecerli_i = 1'b0; ayir_adres_i = '0; ayir_etiket_i = '0; temizle_i = 1'b0;
    oku1_adres_i = '0; oku2_adres_i = '0;
    step(); step();
    rstn_i = 1'b1;
    step();
    chk("reset_state", 5'd5, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 4'h0);

    // write x5, then reset asynchronously in the middle of a cycle
    wb(5'd5, 32'h0000_1234, 4'h0);
    step(); idle();
    chk("write_x5", 5'd5, 32'h1234, 1'b0, 4'h0, 5'd5, 32'h1234, 1'b0, 4'h0);
    rstn_i = 1'b0;
    chk_now("async_reset", 5'd5, 32'h0, 1'b0, 4'h0, 5'd5, 32'h0, 1'b0, 4'h0);
    step();
    rstn_i = 1'b1;
    step();
    chk("after_reset", 5'd5, 32'h0, 1'b0, 4'h0, 5'd5, 32'h0, 1'b0, 4'h0);

    // allocate and retire x3
    ayir(5'd3, 4'd2);
    step(); idle();
    chk("alloc_x3", 5'd3, 32'h0, 1'b1, 4'd2, 5'd0, 32'h0, 1'b0, 4'h0);
    wb(5'd3, 32'hDEAD_BEEF, 4'd2);
    step(); idle();
    chk("retire_x3", 5'd3, 32'hDEAD_BEEF, 1'b0, 4'd2, 5'd3, 32'hDEAD_BEEF, 1'b0, 4'd2);

    // two in-flight writers of x7; older writeback keeps busy
    ayir(5'd7, 4'd1);
    step();
    ayir(5'd7, 4'd4);
    step(); idle();
    chk("alloc_x7_twice", 5'd7, 32'h0, 1'b1, 4'd4, 5'd7, 32'h0, 1'b1, 4'd4);
    wb(5'd7, 32'h0000_00AA, 4'd1);
    step(); idle();
    chk("x7_stale_tag", 5'd7, 32'hAA, 1'b1, 4'd4, 5'd3, 32'hDEAD_BEEF, 1'b0, 4'd2);
    wb(5'd7, 32'h0000_00BB, 4'd4);
    step(); idle();
    chk("x7_young_tag", 5'd7, 32'hBB, 1'b0, 4'd4, 5'd7, 32'hBB, 1'b0, 4'd4);

    // same-cycle writeback and allocation on x9
    ayir(5'd9, 4'd3);
    step(); idle();
    chk("alloc_x9", 5'd9, 32'h0, 1'b1, 4'd3, 5'd9, 32'h0, 1'b1, 4'd3);
    wb(5'd9, 32'h0000_0099, 4'd3);
    ayir(5'd9, 4'd6);
    step(); idle();
    chk("x9_wb_and_alloc", 5'd9, 32'h99, 1'b1, 4'd6, 5'd9, 32'h99, 1'b1, 4'd6);

    // flush drops reservations and the same-cycle allocation, keeps writeback data
    ayir(5'd4, 4'd5);
    step();
    ayir(5'd8, 4'd7);
    step();
    ayir(5'd10, 4'd9);
    temizle_i = 1'b1;
    wb(5'd4, 32'h0000_0044, 4'd0);
    step(); idle();
    chk("flush_x4_x8", 5'd4, 32'h44, 1'b0, 4'd5, 5'd8, 32'h0, 1'b0, 4'd7);
    chk("flush_x10_x9", 5'd10, 32'h0, 1'b0, 4'd0, 5'd9, 32'h99, 1'b0, 4'd6);

    // x0 is hardwired to zero
    wb(5'd0, 32'hFFFF_FFFF, 4'd1);
    ayir(5'd0, 4'd1);
    chk("x0_during", 5'd0, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 4'h0);
    step(); idle();
    chk("x0_after", 5'd0, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 4'h0);

    // writeback visibility on the read ports
    ayir(5'd12, 4'd3);
    step(); idle();
    wb(5'd12, 32'h0000_0055, 4'd3);
`ifdef YO_BYPASS_EN
    chk("x12_same_cycle", 5'd12, 32'h55, 1'b0, 4'd0, 5'd12, 32'h55, 1'b0, 4'd0);
`else
    chk("x12_same_cycle", 5'd12, 32'h0, 1'b1, 4'd3, 5'd12, 32'h0, 1'b1, 4'd3);
`endif
    step(); idle();
    chk("x12_next_cycle", 5'd12, 32'h55, 1'b0, 4'd3, 5'd7, 32'hBB, 1'b0, 4'd4);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
